// File: rtl/smem_bank_rr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : smem_bank_rr_pkg                                            |
// | Brief   : Shared sizing constants for one shared-memory bank and its  |
// |           round-robin core selector.                                  |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package smem_bank_rr_pkg;

  localparam int N_CORES    = 16;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 2 ** ADDR_W;
  localparam int CORE_IDX_W = $clog2(N_CORES);

  // Index 'off' positions after 'base', wrapping modulo N_CORES.
  function automatic logic [CORE_IDX_W-1:0] rr_offset(
    input logic [CORE_IDX_W-1:0] base,
    input int                    off
  );
    int sum;
    sum = (int'(base) + off) % N_CORES;
    return CORE_IDX_W'(sum);
  endfunction

endpackage
`default_nettype wire

// File: rtl/smem_bank_rr_rr_selector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_selector                                                 |
// | Brief   : Registered round-robin pick of the next requesting core.    |
// |           The current core is considered last, so one lone requester  |
// |           re-selects itself; the pick freezes while it is served.     |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module rr_selector
  import smem_bank_rr_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CORES-1:0]    core_val,
  input  logic                  core_serv,
  output logic [CORE_IDX_W-1:0] core_cnt
);

  logic [CORE_IDX_W-1:0] r_cnt;
  logic [CORE_IDX_W-1:0] w_next;
  logic                  w_found;

  // Search forward from the core after the current one; offset N_CORES lands back on the current core.
  always_comb begin
    logic [CORE_IDX_W-1:0] v_idx;
    w_next  = r_cnt;
    w_found = 1'b0;
    v_idx   = r_cnt;
    for (int k = 1; k <= N_CORES; k++) begin
      v_idx = rr_offset(r_cnt, k);
      if (!w_found && core_val[v_idx]) begin
        w_next  = v_idx;
        w_found = 1'b1;
      end
    end
  end

  // Selection register: hold while served or when nobody requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!core_serv && w_found) begin
      r_cnt <= w_next;
    end
  end

  assign core_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/smem_bank_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : smem_bank_rr                                                |
// | Brief   : One byte-wide single-port shared-memory bank with a         |
// |           one-cycle finish pulse, plus its round-robin core selector. |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module smem_bank_rr
  import smem_bank_rr_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CORES-1:0]    core_val,
  input  logic                  core_serv,
  output logic [CORE_IDX_W-1:0] core_cnt,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic                  finish
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_out;
  logic              r_finish;

  rr_selector u_rr_selector (
    .clock     (clock),
    .reset     (reset),
    .core_val  (core_val),
    .core_serv (core_serv),
    .core_cnt  (core_cnt)
  );

  // Bank access: read samples the pre-write word, so read+write returns old data.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_data_out <= '0;
      r_finish   <= 1'b0;
    end else begin
      if (write) begin
        r_mem[addr_in] <= data_in;
      end
      if (read) begin
        r_data_out <= r_mem[addr_in];
      end
      r_finish <= read | write;
    end
  end

  assign data_out = r_data_out;
  assign finish   = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_smem_bank_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_smem_bank_rr                                             |
// | Brief   : Directed and random checks of smem_bank_rr against a        |
// |           behavioural model of the bank and the round-robin rule.     |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_smem_bank_rr;

  logic        clock;
  logic        reset;
  logic [15:0] core_val;
  logic        core_serv;
  logic [3:0]  core_cnt;
  logic        read;
  logic        write;
  logic [7:0]  addr_in;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        finish;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [7:0] m_mem [256];
  int         m_cnt;
  logic [7:0] m_dout;
  logic       m_fin;

  smem_bank_rr dut (
    .clock     (clock),
    .reset     (reset),
    .core_val  (core_val),
    .core_serv (core_serv),
    .core_cnt  (core_cnt),
    .read      (read),
    .write     (write),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .finish    (finish)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of the bank/selector rules to the reference state.
  task automatic model_cycle(input logic rst, input logic [15:0] v, input logic s,
                             input logic rd, input logic wr, input logic [7:0] a,
                             input logic [7:0] d);
    logic [7:0] old;
    if (rst) begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      m_cnt  = 0;
      m_dout = 8'h00;
      m_fin  = 1'b0;
    end else begin
      if (!s && v != 16'h0) begin
        for (int k = 1; k <= 16; k++) begin
          if (v[(m_cnt + k) % 16]) begin
            m_cnt = (m_cnt + k) % 16;
            break;
          end
        end
      end
      old = m_mem[a];
      if (rd) m_dout = old;
      if (wr) m_mem[a] = d;
      m_fin = rd | wr;
    end
  endtask

  // Drive inputs, clock once, then compare all outputs with the model.
  task automatic step(input logic rst, input logic [15:0] v, input logic s,
                      input logic rd, input logic wr, input logic [7:0] a,
                      input logic [7:0] d, input string tag);
    reset = rst; core_val = v; core_serv = s;
    read = rd; write = wr; addr_in = a; data_in = d;
    @(posedge clock);
    #1;
    model_cycle(rst, v, s, rd, wr, a, d);
    check({tag, ".core_cnt"}, 32'(core_cnt), 32'(m_cnt));
    check({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
    check({tag, ".finish"},   32'(finish),   32'(m_fin));
  endtask

  initial begin
    logic [3:0] held;
    int         rot_exp [4];
    reset = 1'b1; core_val = '0; core_serv = 1'b0;
    read = 1'b0; write = 1'b0; addr_in = '0; data_in = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'hxx;
    m_cnt = 0; m_dout = 8'h00; m_fin = 1'b0;

    // Reset for two cycles, then read an arbitrary address
    step(1, 16'h0, 0, 0, 0, 8'h00, 8'h00, "reset0");
    step(1, 16'h0, 0, 0, 0, 8'h00, 8'h00, "reset1");
    check("reset.cnt_const", 32'(core_cnt), 32'd0);
    step(0, 16'h0, 0, 1, 0, 8'h9E, 8'h00, "rd_after_reset");
    check("rd_after_reset.const", 32'(data_out), 32'h00);

    // Write then read back
    step(0, 16'h0, 0, 0, 1, 8'h3C, 8'hA5, "wr3c");
    check("wr3c.fin_const", 32'(finish), 32'd1);
    step(0, 16'h0, 0, 0, 0, 8'h00, 8'h00, "idle0");
    step(0, 16'h0, 0, 1, 0, 8'h3C, 8'h00, "rd3c");
    check("rd3c.const", 32'(data_out), 32'hA5);
    step(0, 16'h0, 0, 0, 0, 8'h00, 8'h00, "idle1");
    check("idle1.fin_const", 32'(finish), 32'd0);

    // Rotation with wrap past 15
    rot_exp[0] = 3; rot_exp[1] = 8; rot_exp[2] = 0; rot_exp[3] = 3;
    for (int i = 0; i < 4; i++) begin
      step(0, 16'h0109, 0, 0, 0, 8'h00, 8'h00, "rot");
      check("rot.seq", 32'(core_cnt), 32'(rot_exp[i]));
    end

    // Hold while served, then advance by exactly one
    held = core_cnt;
    step(0, 16'hFFFF, 1, 0, 0, 8'h00, 8'h00, "hold0");
    step(0, 16'hFFFF, 1, 0, 0, 8'h00, 8'h00, "hold1");
    check("hold.const", 32'(core_cnt), 32'(held));
    step(0, 16'hFFFF, 0, 0, 0, 8'h00, 8'h00, "release");
    check("release.plus1", 32'(core_cnt), 32'(4'(held + 4'd1)));

    // Idle requests hold; a single requester selects itself and stays
    step(0, 16'h0000, 0, 0, 0, 8'h00, 8'h00, "idle_val");
    step(0, 16'h0020, 0, 0, 0, 8'h00, 8'h00, "self0");
    step(0, 16'h0020, 0, 0, 0, 8'h00, 8'h00, "self1");
    check("self.const", 32'(core_cnt), 32'd5);

    // Read+write same cycle returns the old word
    step(0, 16'h0, 0, 0, 1, 8'h07, 8'h11, "wr7");
    step(0, 16'h0, 0, 1, 1, 8'h07, 8'h22, "rw7");
    check("rw7.old_const", 32'(data_out), 32'h11);
    step(0, 16'h0, 0, 1, 0, 8'h07, 8'h00, "rd7");
    check("rd7.new_const", 32'(data_out), 32'h22);

    // Reset right after a write strobe cancels finish and clears memory
    step(0, 16'h0, 0, 0, 1, 8'h40, 8'h5A, "wr40");
    step(1, 16'h0, 0, 0, 0, 8'h00, 8'h00, "rst_mid");
    check("rst_mid.fin_const", 32'(finish), 32'd0);
    step(0, 16'h0, 0, 1, 0, 8'h40, 8'h00, "rd40");

    // Random traffic on a narrow address window to force reuse
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 59) == 0),
           16'($urandom),
           ($urandom_range(0, 2) == 0),
           1'($urandom), 1'($urandom),
           8'($urandom_range(0, 15) | (($urandom_range(0, 7) == 0) ? 8'hF0 : 8'h00)),
           8'($urandom),
           "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
